// File: rtl/gam_winner_search_engine_if.sv
// GAM winner search memory bus: weight and threshold read ports.
// master = search engine (strobe/addr out, data in), slave = memories.
interface gam_winner_search_engine_if #(
  parameter int DIM     = 8,
  parameter int DATA_W  = 8,
  parameter int NODE_AW = 6,
  parameter int DIST_W  = 2*DATA_W+$clog2(DIM)
);
  logic                  w_rd_en;
  logic [NODE_AW-1:0]    w_rd_addr;
  logic [DIM*DATA_W-1:0] w_rd_data;
  logic                  th_rd_en;
  logic [NODE_AW-1:0]    th_rd_addr;
  logic [DIST_W-1:0]     th_rd_data;

  modport master (
    output w_rd_en, w_rd_addr, th_rd_en, th_rd_addr,
    input  w_rd_data, th_rd_data
  );

  modport slave (
    input  w_rd_en, w_rd_addr, th_rd_en, th_rd_addr,
    output w_rd_data, th_rd_data
  );
endinterface

// File: rtl/gam_winner_search_engine.sv
// GAM nearest-two-node search: streams a class through a squared-ED unit,
// tracks min1/min2, then checks min1 against its threshold.
// Ports: clk, rst_n, start, x_in, node_count -> busy, done, results;
// mem (master) carries the weight and threshold read buses.
module gam_winner_search_engine #(
  parameter int DIM      = 8,
  parameter int DATA_W   = 8,
  parameter int NODE_MAX = 64,
  parameter int NODE_AW  = 6,
  parameter int RD_LAT   = 1,
  parameter int DIST_W   = 2*DATA_W+$clog2(DIM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM*DATA_W-1:0] x_in,
  input  logic [NODE_AW:0]      node_count,
  output logic                  busy,
  output logic                  done,
  gam_winner_search_engine_if.master mem,
  output logic [NODE_AW-1:0]    min1_node,
  output logic [NODE_AW-1:0]    min2_node,
  output logic [DIST_W-1:0]     min1_dist,
  output logic [DIST_W-1:0]     min2_dist,
  output logic                  min1_valid,
  output logic                  min2_valid,
  output logic                  new_node
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_TH,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t                state;
  logic [DIM*DATA_W-1:0] x_q;
  logic [NODE_AW:0]      n_q;
  logic [NODE_AW:0]      n_sat;
  logic                  w_en;
  logic [NODE_AW-1:0]    w_addr;
  logic                  th_en;
  logic [RD_LAT-1:0]     rd_vld;
  logic                  dist_vld;
  logic [DIST_W-1:0]     dist_q;
  logic [DIST_W-1:0]     dist_d;
  logic [NODE_AW-1:0]    k_idx;
  logic [1:0]            wait_cnt;
  logic                  last_addr;

  logic [DATA_W-1:0]     xe;
  logic [DATA_W-1:0]     we;
  logic [DATA_W-1:0]     ad;
  logic [2*DATA_W-1:0]   sq;

  assign mem.w_rd_en    = w_en;
  assign mem.w_rd_addr  = w_addr;
  assign mem.th_rd_en   = th_en;
  assign mem.th_rd_addr = min1_node;

  assign n_sat = (node_count > (NODE_AW+1)'(NODE_MAX))
               ? (NODE_AW+1)'(NODE_MAX) : node_count;

  assign last_addr = ({1'b0, w_addr} + 1'b1) == n_q;

  // |x-w|^2 equals the signed (DATA_W+1)-bit difference squared,
  // and keeps the product unsigned and exactly 2*DATA_W wide.
  always_comb begin
    dist_d = '0;
    xe     = '0;
    we     = '0;
    ad     = '0;
    sq     = '0;
    for (int i = 0; i < DIM; i++) begin
      xe = x_q[i*DATA_W +: DATA_W];
      we = mem.w_rd_data[i*DATA_W +: DATA_W];
      ad = (xe >= we) ? (xe - we) : (we - xe);
      sq = {{DATA_W{1'b0}}, ad} * {{DATA_W{1'b0}}, ad};
      dist_d = dist_d + DIST_W'(sq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      x_q        <= '0;
      n_q        <= '0;
      w_en       <= 1'b0;
      w_addr     <= '0;
      th_en      <= 1'b0;
      rd_vld     <= '0;
      dist_vld   <= 1'b0;
      dist_q     <= '0;
      k_idx      <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      min1_node  <= '0;
      min2_node  <= '0;
      min1_dist  <= '1;
      min2_dist  <= '1;
      min1_valid <= 1'b0;
      min2_valid <= 1'b0;
      new_node   <= 1'b0;
    end else begin
      // read-return tracking: one bit per in-flight weight read
      rd_vld[0] <= w_en;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld[i] <= rd_vld[i-1];
      end
      dist_vld <= rd_vld[RD_LAT-1];
      if (rd_vld[RD_LAT-1]) begin
        dist_q <= dist_d;
      end

      // reads issue 0..N-1 in order, so a counter names each distance
      if (dist_vld) begin
        k_idx <= k_idx + 1'b1;
        if (dist_q < min1_dist) begin
          min2_node  <= min1_node;
          min2_dist  <= min1_dist;
          min2_valid <= min1_valid;
          min1_node  <= k_idx;
          min1_dist  <= dist_q;
          min1_valid <= 1'b1;
        end else if (dist_q < min2_dist) begin
          min2_node  <= k_idx;
          min2_dist  <= dist_q;
          min2_valid <= 1'b1;
        end
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            x_q        <= x_in;
            n_q        <= n_sat;
            k_idx      <= '0;
            min1_node  <= '0;
            min2_node  <= '0;
            min1_dist  <= '1;
            min2_dist  <= '1;
            min1_valid <= 1'b0;
            min2_valid <= 1'b0;
            busy       <= 1'b1;
            if (n_sat == '0) begin
              new_node <= 1'b1;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              new_node <= 1'b0;
              w_en     <= 1'b1;
              w_addr   <= '0;
              state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (last_addr) begin
            w_en  <= 1'b0;
            state <= S_DRAIN;
          end else begin
            w_addr <= w_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // last distance lands in min regs on this edge
          if (dist_vld && !(|rd_vld)) begin
            th_en    <= 1'b1;
            wait_cnt <= '0;
            state    <= S_TH;
          end
        end
        S_TH: begin
          th_en <= 1'b0;
          if (wait_cnt == 2'(RD_LAT-1)) begin
            state <= S_DECIDE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECIDE: begin
          new_node <= min1_dist > mem.th_rd_data;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gam_winner_search_engine.sv
// Directed bench for gam_winner_search_engine: three instances cover
// RD_LAT=1/2 with DIM=4, and DIM=8 for full-range distances.
module tb_gam_winner_search_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] v4(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  logic [31:0] x4;
  logic [63:0] x8;
  logic [6:0]  nc;
  logic start_a, start_b, start_c;

  logic [31:0] wm4 [64];
  logic [17:0] thm4 [64];
  logic [63:0] w8_0;
  logic [18:0] th8_0;

  // ---- instance a: DIM=4, RD_LAT=1
  logic busy_a, done_a, m1v_a, m2v_a, nn_a;
  logic [5:0] m1n_a, m2n_a;
  logic [17:0] m1d_a, m2d_a;
  gam_winner_search_engine_if #(.DIM(4), .DATA_W(8), .NODE_AW(6),
    .DIST_W(18)) mem_a ();
  gam_winner_search_engine #(.DIM(4), .DATA_W(8), .NODE_MAX(64),
    .NODE_AW(6), .RD_LAT(1), .DIST_W(18)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .x_in(x4),
    .node_count(nc), .busy(busy_a), .done(done_a), .mem(mem_a),
    .min1_node(m1n_a), .min2_node(m2n_a), .min1_dist(m1d_a),
    .min2_dist(m2d_a), .min1_valid(m1v_a), .min2_valid(m2v_a),
    .new_node(nn_a));

  always @(posedge clk) begin
    mem_a.w_rd_data  <= mem_a.w_rd_en ? wm4[mem_a.w_rd_addr] : 'x;
    mem_a.th_rd_data <= mem_a.th_rd_en ? thm4[mem_a.th_rd_addr] : 'x;
  end

  int waddr_a[$];
  int wcyc_a[$];
  int thcnt_a = 0;
  always @(negedge clk) begin
    if (mem_a.w_rd_en) begin
      waddr_a.push_back(int'(mem_a.w_rd_addr));
      wcyc_a.push_back(cyc);
    end
    if (mem_a.th_rd_en) thcnt_a++;
  end

  // ---- instance b: DIM=4, RD_LAT=2
  logic busy_b, done_b, m1v_b, m2v_b, nn_b;
  logic [5:0] m1n_b, m2n_b;
  logic [17:0] m1d_b, m2d_b;
  gam_winner_search_engine_if #(.DIM(4), .DATA_W(8), .NODE_AW(6),
    .DIST_W(18)) mem_b ();
  gam_winner_search_engine #(.DIM(4), .DATA_W(8), .NODE_MAX(64),
    .NODE_AW(6), .RD_LAT(2), .DIST_W(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x_in(x4),
    .node_count(nc), .busy(busy_b), .done(done_b), .mem(mem_b),
    .min1_node(m1n_b), .min2_node(m2n_b), .min1_dist(m1d_b),
    .min2_dist(m2d_b), .min1_valid(m1v_b), .min2_valid(m2v_b),
    .new_node(nn_b));

  logic [31:0] wb1;
  logic [17:0] tb1;
  always @(posedge clk) begin
    wb1 <= mem_b.w_rd_en ? wm4[mem_b.w_rd_addr] : 'x;
    mem_b.w_rd_data <= wb1;
    tb1 <= mem_b.th_rd_en ? thm4[mem_b.th_rd_addr] : 'x;
    mem_b.th_rd_data <= tb1;
  end

  int wcnt_b = 0;
  int thcnt_b = 0;
  always @(negedge clk) begin
    if (mem_b.w_rd_en) wcnt_b++;
    if (mem_b.th_rd_en) thcnt_b++;
  end

  // ---- instance c: DIM=8, RD_LAT=1, DIST_W=19
  logic busy_c, done_c, m1v_c, m2v_c, nn_c;
  logic [5:0] m1n_c, m2n_c;
  logic [18:0] m1d_c, m2d_c;
  gam_winner_search_engine_if #(.DIM(8), .DATA_W(8), .NODE_AW(6),
    .DIST_W(19)) mem_c ();
  gam_winner_search_engine #(.DIM(8), .DATA_W(8), .NODE_MAX(64),
    .NODE_AW(6), .RD_LAT(1), .DIST_W(19)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .x_in(x8),
    .node_count(nc), .busy(busy_c), .done(done_c), .mem(mem_c),
    .min1_node(m1n_c), .min2_node(m2n_c), .min1_dist(m1d_c),
    .min2_dist(m2d_c), .min1_valid(m1v_c), .min2_valid(m2v_c),
    .new_node(nn_c));

  always @(posedge clk) begin
    mem_c.w_rd_data  <= (mem_c.w_rd_en && mem_c.w_rd_addr == 6'd0)
                      ? w8_0 : 'x;
    mem_c.th_rd_data <= (mem_c.th_rd_en && mem_c.th_rd_addr == 6'd0)
                      ? th8_0 : 'x;
  end

  // ---- helpers
  function automatic logic dn(int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic go(int sel, int n, output int t);
    @(negedge clk);
    nc = 7'(n);
    case (sel)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    t = cyc;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_done(int sel, output int d);
    d = -1000;
    for (int k = 0; k < 200; k++) begin
      if (dn(sel)) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  int t, d, base, thb, hit;

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    x4 = '0;
    x8 = '0;
    nc = '0;
    for (int i = 0; i < 64; i++) begin
      wm4[i]  = v4(10, 10, 10, 10);
      thm4[i] = 18'd0;
    end
    w8_0  = '0;
    th8_0 = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst0_flags", {busy_a, done_a, mem_a.w_rd_en, mem_a.th_rd_en,
                       m1v_a, m2v_a, nn_a}, 0);
    chk("rst0_m1d", m1d_a, 64'h3FFFF);
    chk("rst0_m2d", m2d_a, 64'h3FFFF);
    chk("rst0_m1n", m1n_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N == 0
    base = waddr_a.size();
    thb  = thcnt_a;
    go(0, 0, t);
    wait_done(0, d);
    chk("n0_lat", d - t, 1);
    chk("n0_busy", busy_a, 1);
    chk("n0_new", nn_a, 1);
    chk("n0_valid", {m1v_a, m2v_a}, 0);
    chk("n0_wreads", waddr_a.size() - base, 0);
    chk("n0_threads", thcnt_a - thb, 0);
    @(negedge clk);
    chk("n0_idle", {busy_a, done_a}, 0);

    // N == 1, equal distance and threshold
    x4     = v4(10, 10, 10, 10);
    wm4[0] = v4(12, 10, 10, 7);
    thm4[0] = 18'd13;
    go(0, 1, t);
    wait_done(0, d);
    chk("n1_lat", d - t, 6);
    chk("n1_m1", {m1v_a, m1n_a, m1d_a}, {1'b1, 6'd0, 18'd13});
    chk("n1_m2v", m2v_a, 0);
    chk("n1_m2d", m2d_a, 64'h3FFFF);
    chk("n1_new", nn_a, 0);
    @(negedge clk);
    chk("n1_hold", m1d_a, 13);

    // N == 4 with tie at distance 20
    wm4[0]  = v4(17, 11, 10, 10);
    wm4[1]  = v4(14, 12, 10, 10);
    wm4[2]  = v4(15, 13, 11, 10);
    wm4[3]  = v4(6, 8, 10, 10);
    thm4[1] = 18'd19;
    base = waddr_a.size();
    go(0, 4, t);
    wait_done(0, d);
    chk("n4_lat", d - t, 9);
    chk("n4_m1", {m1v_a, m1n_a, m1d_a}, {1'b1, 6'd1, 18'd20});
    chk("n4_m2", {m2v_a, m2n_a, m2d_a}, {1'b1, 6'd3, 18'd20});
    chk("n4_new", nn_a, 1);
    chk("n4_nreads", waddr_a.size() - base, 4);
    if (waddr_a.size() - base == 4) begin
      chk("n4_first", wcyc_a[base] - t, 1);
      for (int i = 0; i < 4; i++) begin
        chk("n4_addr", waddr_a[base+i], i);
        chk("n4_cyc", wcyc_a[base+i] - wcyc_a[base], i);
      end
    end

    // RD_LAT = 2, start pulsed during busy
    x4      = v4(10, 10, 10, 10);
    wm4[0]  = v4(12, 11, 10, 10);
    wm4[1]  = v4(13, 10, 10, 10);
    wm4[2]  = v4(11, 10, 10, 10);
    thm4[2] = 18'd1;
    go(1, 3, t);
    @(negedge clk);
    x4 = v4(0, 0, 0, 0);
    nc = 7'd5;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1, d);
    chk("l2_lat", d - t, 10);
    chk("l2_m1", {m1v_b, m1n_b, m1d_b}, {1'b1, 6'd2, 18'd1});
    chk("l2_m2", {m2v_b, m2n_b, m2d_b}, {1'b1, 6'd0, 18'd5});
    chk("l2_new", nn_b, 0);
    repeat (4) @(negedge clk);
    chk("l2_busy", busy_b, 0);
    chk("l2_wreads", wcnt_b, 3);
    chk("l2_threads", thcnt_b, 1);

    // reset mid-fetch, then a short search
    x4 = v4(10, 10, 10, 10);
    wm4[0] = v4(12, 12, 10, 10);
    wm4[1] = v4(11, 11, 11, 10);
    wm4[2] = v4(10, 10, 10, 10);
    for (int i = 3; i < 8; i++) wm4[i] = v4(10, 10, 10, 11);
    thm4[1] = 18'd5;
    go(0, 8, t);
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_a.w_rd_en && mem_a.w_rd_addr == 6'd2) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rs_at2", hit, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_flags", {busy_a, done_a, mem_a.w_rd_en, mem_a.th_rd_en,
                     m1v_a, m2v_a, nn_a}, 0);
    chk("rs_mins", {m1n_a, m2n_a, m1d_a, m2d_a},
        {6'd0, 6'd0, 18'h3FFFF, 18'h3FFFF});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rs_idle", {busy_a, done_a}, 0);
    base = waddr_a.size();
    go(0, 2, t);
    wait_done(0, d);
    chk("rs_lat", d - t, 7);
    chk("rs_nreads", waddr_a.size() - base, 2);
    if (waddr_a.size() - base == 2) begin
      chk("rs_addr0", waddr_a[base], 0);
      chk("rs_addr1", waddr_a[base+1], 1);
    end
    chk("rs_m1", {m1v_a, m1n_a, m1d_a}, {1'b1, 6'd1, 18'd3});
    chk("rs_m2", {m2v_a, m2n_a, m2d_a}, {1'b1, 6'd0, 18'd8});
    chk("rs_new", nn_a, 0);

    // DIM = 8 full-range distance
    x8    = '1;
    w8_0  = '0;
    th8_0 = '0;
    go(2, 1, t);
    wait_done(2, d);
    chk("big_lat", d - t, 6);
    chk("big_m1", {m1v_c, m1n_c, m1d_c}, {1'b1, 6'd0, 19'd520200});
    chk("big_m2v", m2v_c, 0);
    chk("big_new", nn_c, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gam_winner_search_engine.md
Name: gam_winner_search_engine

Overview:
- Parametrised sequential nearest-two-node search for the GAM memory layer.
- On `start`, it streams every stored weight vector of one class from node memory through a pipelined squared-Euclidean-distance unit.
- It tracks the first and second winners, then reads the winner's threshold and decides between "insert new node" and "update winner".
- It replaces the single-width, combinational ED plus min-finder path with a handshaked engine configurable in dimension, element width, node depth and memory read latency.

Parameters:
- DIM, 8, elements per node vector (>=1)
- DATA_W, 8, unsigned element width
- NODE_MAX, 64, max nodes per class
- NODE_AW, 6, node address width (clog2(NODE_MAX))
- RD_LAT, 1, read latency of weight and threshold memories (1 or 2)
- DIST_W, 2*DATA_W+$clog2(DIM), distance/threshold width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request search; sampled only in IDLE
- x_in  in  DIM*DATA_W  input vector, captured at accepted start
- node_count  in  NODE_AW+1  nodes in class, captured at start
- busy  out  1  high from cycle after accepted start through done cycle
- done  out  1  one-cycle pulse, results valid
- w_rd_en  out  1  weight memory read strobe
- w_rd_addr  out  NODE_AW  node index
- w_rd_data  in  DIM*DATA_W  weight vector, valid RD_LAT cycles after strobe
- th_rd_en  out  1  threshold read strobe
- th_rd_addr  out  NODE_AW  node index
- th_rd_data  in  DIST_W  threshold, valid RD_LAT cycles after strobe
- min1_node, min2_node  out  NODE_AW  winner indices
- min1_dist, min2_dist  out  DIST_W  winner distances
- min1_valid, min2_valid  out  1  winner exists
- new_node  out  1  1 = insert x as new node, 0 = update min1

Behaviour:
- Reset: asynchronous, from any state, mid-search included.
  - State goes to IDLE.
  - All outputs go to 0; min1_dist and min2_dist go to all-ones.
  - In-flight reads are discarded.
- FSM states:
  - IDLE: on start, capture x_in and node_count, saturating node_count to NODE_MAX. Clear min registers to node 0, distance all-ones, valid 0. Go to FETCH, or to DONE if node_count==0.
  - FETCH: assert w_rd_en one node per cycle, addr 0..N-1 ascending. After addr N-1, go to DRAIN.
  - DRAIN: wait until the last distance has updated the min registers.
  - TH: one-cycle th_rd_en with th_rd_addr=min1_node. Wait RD_LAT cycles.
  - DECIDE: new_node = (min1_dist > th_rd_data), strict. Go to DONE.
  - DONE: done=1 for one cycle. Return to IDLE.
- Distance pipeline:
  - Per element, diff is signed DATA_W+1 and the square is 2*DATA_W unsigned.
  - The adder tree sums to DIST_W with no saturation needed.
  - The result is registered one cycle after w_rd_data is valid.
  - Min update occurs at the edge following the registered distance.
- Min update, strict compare:
  - If d < min1: min2 <= min1 (including valid), min1 <= (k, d).
  - Else if d < min2: min2 <= (k, d).
  - Ties keep the earlier index as min1. A node equal to min1 becomes min2 if below current min2.
  - valid flags set when a slot is first written.
- Latency: start accepted in cycle T with N>=1 gives done in cycle T+N+2*RD_LAT+3. N==0 gives done at T+1 with new_node=1, both valid=0, and no memory strobes.
- N==1: min2_valid=0 and min2_dist stays all-ones. New_node is decided by threshold.
- start while busy is ignored with no effect. start in the done cycle is ignored; it is accepted next cycle.
- Result outputs hold from done until the next accepted start. busy and done are 0 in IDLE.

Test Plan:
- DIM=4, DATA_W=8, RD_LAT=1, node_count=0, start -> done at T+1, new_node=1, min1_valid=min2_valid=0, w_rd_en never high.
- node_count=1, x=(10,10,10,10), w0=(12,10,10,7), th0=13 -> min1=(0,13), min2_valid=0, new_node=0 (equal is not greater); done at T+6.
- node_count=4, squared distances {50,20,35,20}, th1=19 -> min1=(1,20), min2=(3,20), new_node=1; w_rd_addr 0,1,2,3 on consecutive cycles; done at T+9.
- RD_LAT=2, node_count=3, distances {5,9,1} -> min1=(2,1), min2=(0,5), done at T+10; start pulsed during busy -> no restart and no extra reads.
- Reset asserted in FETCH at node 2 of 8, then released, then new start with node_count=2 -> all outputs 0 while reset; next search reads only addr 0,1 and results reflect only that search.
- DATA_W=8, DIM=8, all x=255, all w=0 -> min1_dist=8*65025=520200 without overflow (DIST_W=19).
